// File: rtl/bcd_scan_display.sv
// Time-multiplexed 3-digit 7-segment driver for BCD hundreds/tens/ones.
// Digits are latched once per scan frame; outputs are registered one cycle behind the scan index.
module bcd_scan_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       blank_lz,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int             PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]     AN_OFF    = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        IDX_ONES     = 2'd0,
        IDX_TENS     = 2'd1,
        IDX_HUNDREDS = 2'd2
    } idx_e;

    logic [PW-1:0] presc_q;
    idx_e          idx_q;
    idx_e          idx_d;
    logic          en_q;
    logic [3:0]    sh_h_q, sh_t_q, sh_o_q;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          fd_q;

    logic          tick;
    logic [3:0]    digit;
    logic [2:0]    an_sel;
    logic          blank;
    logic [6:0]    lit;

    always_comb begin
        tick   = (presc_q == PRESC_MAX);
        idx_d  = IDX_ONES;
        digit  = '0;
        an_sel = '0;
        blank  = 1'b1;
        case (idx_q)
            IDX_ONES: begin
                idx_d  = IDX_TENS;
                digit  = sh_o_q;
                an_sel = 3'b001;
                blank  = 1'b0;
            end
            IDX_TENS: begin
                idx_d  = IDX_HUNDREDS;
                digit  = sh_t_q;
                an_sel = 3'b010;
                blank  = blank_lz && (sh_h_q == 4'd0) && (sh_t_q == 4'd0);
            end
            IDX_HUNDREDS: begin
                idx_d  = IDX_ONES;
                digit  = sh_h_q;
                an_sel = 3'b100;
                blank  = blank_lz && (sh_h_q == 4'd0);
            end
            default: idx_d = IDX_ONES;
        endcase

        case (digit)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = 7'h40;
        endcase
        if (blank) lit = '0;

        seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
        an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= IDX_ONES;
            en_q    <= 1'b0;
            sh_h_q  <= '0;
            sh_t_q  <= '0;
            sh_o_q  <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            fd_q    <= 1'b0;
        end else if (!enable) begin
            presc_q <= '0;
            idx_q   <= IDX_ONES;
            en_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            fd_q    <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            fd_q    <= tick && (idx_q == IDX_HUNDREDS);
            if (tick) idx_q <= idx_d;
            if (tick && (idx_q == IDX_HUNDREDS)) begin
                sh_h_q <= hundreds;
                sh_t_q <= tens;
                sh_o_q <= ones;
            end
            // Outputs stay dark for the first enabled cycle so the ones digit appears on the 2nd edge.
            if (en_q) begin
                seg_q <= seg_d;
                an_q  <= an_d;
            end else begin
                seg_q <= SEG_OFF;
                an_q  <= AN_OFF;
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign dp         = SEG_ACTIVE_LOW;

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the binary-to-BCD converter: takes its three 4-bit BCD digits (hundreds/tens/ones) and time-multiplexes them onto a 3-digit common-anode/cathode 7-segment display.
- Latches digits once per scan frame (tear-free), applies optional leading-zero blanking, flags invalid BCD.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is lit (>=2).
- SEG_ACTIVE_LOW, 1, 1: seg/dp outputs inverted (lit = 0).
- AN_ACTIVE_LOW, 1, 1: an outputs inverted (selected = 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan running; 0 = display dark.
- blank_lz  in  1  1 = suppress leading zeros.
- hundreds  in  4  BCD hundreds digit from converter.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dp  out  1  decimal point, always unlit.
- an  out  3  digit select {hundreds,tens,ones}, one-hot when active, polarity per AN_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0 (ones), shadow digits=0, an all inactive, seg all unlit, dp unlit, frame_done=0. Reset mid-frame aborts immediately; no partial state survives.
- Prescaler: counts 0..REFRESH_DIV-1 while enable=1, wraps to 0; tick = (prescaler==REFRESH_DIV-1).
- Scan FSM idx: ONES(0) -> TENS(1) -> HUNDREDS(2) -> ONES; advances only on tick edge; value 3 unreachable (if ever reached, next state ONES).
- Frame boundary: tick with idx==HUNDREDS. On that edge: shadow <= {hundreds,tens,ones}, frame_done <= 1 for exactly one cycle, idx <= ONES. Inputs are ignored at all other times.
- Output pipeline: seg/an registered from (idx, shadow) with 1-cycle latency; after an idx change, an/seg show the new digit one cycle later. an and seg always change on the same edge (never mismatched).
- Decode (lit pattern, before polarity): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; 10-15 = dash 0x40.
- Blanking when blank_lz=1: hundreds digit blank if shadow_h==0; tens blank if shadow_h==0 and shadow_t==0; ones never blanked. Blank digit: seg all unlit, an still selected. Invalid digit (>9) counts as non-zero for blanking.
- enable=0: synchronously, next edge: prescaler=0, idx=ONES, an all inactive, seg unlit, frame_done=0; shadow retained. Re-enable: ones digit lit 1 cycle after enable rises is NOT required; the first an assertion (ones) occurs on the 2nd edge after enable=1, then first advance after REFRESH_DIV cycles.
- enable falling on a tick edge: enable wins (no advance, no frame_done).
- blank_lz is applied combinationally into the output register (takes effect on next output register update, no frame latch).

Test Plan:
- Reset: REFRESH_DIV=4, active-low params, rst_n=0 mid-scan -> immediately an=3'b111, seg=7'h7F, frame_done=0; after release and enable=1, shadow=0 so ones shows seg=~0x3F=7'h40, an=3'b110.
- Scan order/timing: REFRESH_DIV=4, inputs 1/2/3 held -> frame_done pulses every 12 cycles; after first pulse, an sequence 110,101,011 each for 4 cycles with seg ~0x4F(3), ~0x5B(2), ~0x06(1) in ones/tens/hundreds slots.
- Tear-free latch: change inputs from 1/2/3 to 4/5/6 mid-frame -> displayed digits stay 1/2/3 until next frame_done, then 4/5/6.
- Leading-zero blank: inputs 0/0/7, blank_lz=1 -> hundreds and tens slots seg all unlit, ones shows 7; blank_lz=0 -> shows 0,0,7. Inputs 0/5/0 blank_lz=1 -> only hundreds blank.
- Invalid BCD: ones=4'hC -> ones slot shows dash (lit 0x40); hundreds=0,tens=0,ones=0xC with blank_lz=1 -> hundreds/tens blank, dash shown.
- Enable gating: drop enable mid-TENS -> next edge an inactive, seg unlit, no frame_done; re-raise -> scan restarts at ONES, full 12-cycle frame before next frame_done.
